// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for arith_pipe: wrap/saturate mode encoding
// and the full-precision overflow-detecting add used by sat_add.
package arith_pkg;

    typedef enum logic [0:0] {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } arith_mode_e;

    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] res;
    } add_res_t;

    // Operands arrive already sign-extended, so the wide sum is exact; overflow
    // is judged against the signed range of a width-bit result.
    function automatic add_res_t sat_add_fn(
        input wide_t       x,
        input wide_t       y,
        input int          width,
        input arith_mode_e mode
    );
        wide_t    s;
        wide_t    max_pos;
        wide_t    min_neg;
        add_res_t r;
        s       = x + y;
        max_pos = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_neg = -max_pos - 64'sd1;
        r.ovf   = (s > max_pos) || (s < min_neg);
        if (r.ovf && (mode == MODE_SAT)) begin
            r.res = s[MAX_W-1] ? min_neg : max_pos;
        end else begin
            r.res = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed WIDTH-bit add/subtract with overflow flag and optional saturation.
module sat_add
    import arith_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SAT   = 0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_res,
    output logic             o_ovf
);
    localparam arith_mode_e MODE = (SAT != 0) ? MODE_SAT : MODE_WRAP;

    wide_t                  w_a_ext;
    wide_t                  w_b_ext;
    add_res_t               w_r;
    logic [MAX_W-1:WIDTH]   w_unused_hi;

    assign w_a_ext     = wide_t'(signed'(i_a));
    assign w_b_ext     = i_sub ? -wide_t'(signed'(i_b)) : wide_t'(signed'(i_b));
    assign w_r         = sat_add_fn(w_a_ext, w_b_ext, WIDTH, MODE);
    assign o_res       = w_r.res[WIDTH-1:0];
    assign o_ovf       = w_r.ovf;
    assign w_unused_hi = w_r.res[MAX_W-1:WIDTH];

endmodule

// File: rtl/arith_pipe.sv
// Pipelined signed add/subtract with a handshaked output accumulator.
// One advance enable moves every stage, so a stalled output freezes the pipe.
module arith_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans_sum,
    output logic [WIDTH-1:0] ans_diff,
    output logic [WIDTH-1:0] ans_acc,
    output logic             ovf
);
    typedef struct packed {
        logic             vld;
        logic             ovf;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] diff;
    } stage_t;

    stage_t           r_stage [DEPTH];
    stage_t           w_stage0;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_acc_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] r_acc;
    logic             w_sum_ovf;
    logic             w_diff_ovf;
    logic             w_acc_ovf_unused;
    logic             w_adv;
    logic             w_hs;

    sat_add #(.WIDTH(WIDTH), .SAT(SAT)) u_sum (
        .i_a(a), .i_b(b), .i_sub(1'b0), .o_res(w_sum), .o_ovf(w_sum_ovf)
    );

    sat_add #(.WIDTH(WIDTH), .SAT(SAT)) u_diff (
        .i_a(a), .i_b(b), .i_sub(1'b1), .o_res(w_diff), .o_ovf(w_diff_ovf)
    );

    // Accumulator overflow is deliberately not reported on ovf.
    sat_add #(.WIDTH(WIDTH), .SAT(SAT)) u_acc (
        .i_a(r_acc), .i_b(ans_sum), .i_sub(1'b0), .o_res(w_acc_sum), .o_ovf(w_acc_ovf_unused)
    );

    assign w_adv     = !out_valid || out_ready;
    assign w_hs      = out_valid && out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_stage[DEPTH-1].vld;
    assign ans_sum   = r_stage[DEPTH-1].sum;
    assign ans_diff  = r_stage[DEPTH-1].diff;
    assign ovf       = r_stage[DEPTH-1].ovf;
    assign ans_acc   = r_acc;

    // Stage-0 payload: bubbles carry zero data so idle outputs stay quiet
    always_comb begin
        w_stage0 = '0;
        if (in_valid) begin
            w_stage0.vld  = 1'b1;
            w_stage0.ovf  = w_sum_ovf || w_diff_ovf;
            w_stage0.sum  = w_sum;
            w_stage0.diff = w_diff;
        end else begin
            w_stage0 = '0;
        end
    end

    // Pipeline register chain, all stages advance together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (w_adv) begin
            r_stage[0] <= w_stage0;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Accumulator next value: clear wins over accumulate but still keeps the delivered sum
    always_comb begin
        w_acc_next = r_acc;
        if (w_hs) begin
            w_acc_next = clr ? ans_sum : w_acc_sum;
        end else if (clr) begin
            w_acc_next = '0;
        end else begin
            w_acc_next = r_acc;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: tb/tb_arith_pipe.sv
// Bench for arith_pipe: wrap and saturate instances share stimulus and are
// scored against an integer model of accepted items and the accumulator.
module tb_arith_pipe;
    localparam int W   = 4;
    localparam int D   = 3;
    localparam int LIM = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic         out_ready;
    logic         in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [W-1:0] sum0, sum1, diff0, diff1, acc_o0, acc_o1;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    bit mon_en   = 1'b0;

    int qa[$];
    int qb[$];
    int acc0, acc1;
    int ia, ib, es, ed, hs0;
    bit prev_stall;
    int p_sum, p_diff, p_ovf, p_sum1;

    always #5 clk = ~clk;

    arith_pipe #(.WIDTH(W), .DEPTH(D), .SAT(0)) u_dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .clr(clr), .out_valid(out_valid0), .out_ready(out_ready),
        .ans_sum(sum0), .ans_diff(diff0), .ans_acc(acc_o0), .ovf(ovf0)
    );

    arith_pipe #(.WIDTH(W), .DEPTH(D), .SAT(1)) u_dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .clr(clr), .out_valid(out_valid1), .out_ready(out_ready),
        .ans_sum(sum1), .ans_diff(diff1), .ans_acc(acc_o1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fold(input int v, input bit sat);
        int r;
        r = v;
        if (sat) begin
            if (v > LIM - 1) r = LIM - 1;
            else if (v < -LIM) r = -LIM;
        end
        return r & (2 * LIM - 1);
    endfunction

    function automatic int sx(input int u);
        return (u >= LIM) ? u - 2 * LIM : u;
    endfunction

    function automatic int ovf_of(input int v);
        return (v > LIM - 1 || v < -LIM) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int av, input int bv, input bit c, input bit r);
        in_valid  = v;
        a         = W'(av);
        b         = W'(bv);
        clr       = c;
        out_ready = r;
    endtask

    // Monitor: inputs and outputs are settled at the falling edge for the coming rising edge
    always @(negedge clk) begin
        if (mon_en && reset) begin
            chk("in_ready_wrap", in_ready0, (!out_valid0 || out_ready) ? 1 : 0);
            chk("in_ready_sat", in_ready1, (!out_valid1 || out_ready) ? 1 : 0);
            chk("valid_match", out_valid1, out_valid0);
            if (prev_stall) begin
                chk("hold_valid", out_valid0, 1);
                chk("hold_sum", sum0, p_sum);
                chk("hold_diff", diff0, p_diff);
                chk("hold_ovf", ovf0, p_ovf);
                chk("hold_sum_sat", sum1, p_sum1);
            end
            chk("acc_wrap", acc_o0, fold(acc0, 1'b0));
            chk("acc_sat", acc_o1, fold(acc1, 1'b1));
            if (out_valid0 && out_ready) begin
                n_hs++;
                if (qa.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    ia = qa.pop_front();
                    ib = qb.pop_front();
                    es = ia + ib;
                    ed = ia - ib;
                    chk("sum_wrap", sum0, fold(es, 1'b0));
                    chk("sum_sat", sum1, fold(es, 1'b1));
                    chk("diff_wrap", diff0, fold(ed, 1'b0));
                    chk("diff_sat", diff1, fold(ed, 1'b1));
                    chk("ovf_wrap", ovf0, ovf_of(es) | ovf_of(ed));
                    chk("ovf_sat", ovf1, ovf_of(es) | ovf_of(ed));
                    if (clr) begin
                        acc0 = sx(fold(es, 1'b0));
                        acc1 = sx(fold(es, 1'b1));
                    end else begin
                        acc0 = sx(fold(acc0 + sx(fold(es, 1'b0)), 1'b0));
                        acc1 = sx(fold(acc1 + sx(fold(es, 1'b1)), 1'b1));
                    end
                end
            end else if (clr) begin
                acc0 = 0;
                acc1 = 0;
            end
            if (in_valid && in_ready0) begin
                qa.push_back(sx(int'(a)));
                qb.push_back(sx(int'(b)));
            end
            prev_stall = out_valid0 && !out_ready;
            p_sum  = sum0;
            p_diff = diff0;
            p_ovf  = ovf0;
            p_sum1 = sum1;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid0 | out_valid1, 0);
        chk({tag, "_in_ready"}, in_ready0 & in_ready1, 1);
        chk({tag, "_sum"}, int'(sum0) + int'(sum1), 0);
        chk({tag, "_diff"}, int'(diff0) + int'(diff1), 0);
        chk({tag, "_acc"}, int'(acc_o0) + int'(acc_o1), 0);
        chk({tag, "_ovf"}, ovf0 | ovf1, 0);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        acc0 = 0;
        acc1 = 0;
        prev_stall = 1'b0;
        #3;
        check_reset_state("por");
        tick();
        reset  = 1'b1;
        mon_en = 1'b1;

        // Latency and back-to-back items
        drive(1, 3, 1, 0, 1);  tick();
        drive(1, -2, 1, 0, 1); tick();
        chk("lat_early", out_valid0, 0);
        drive(0, 0, 0, 0, 1);  tick();
        chk("lat_valid", out_valid0, 1);
        chk("lat_sum", sum0, 4);
        chk("lat_diff", diff0, 2);
        chk("lat_ovf", ovf0, 0);
        tick();
        chk("b2b_valid", out_valid0, 1);
        chk("b2b_sum", sum0, 15);
        chk("b2b_diff", diff0, 13);
        chk("b2b_ovf", ovf0, 0);
        chk("b2b_acc", acc_o0, 4);
        tick();
        chk("b2b_acc2", acc_o0, 3);
        chk("b2b_idle", out_valid0, 0);

        // Overflow under wrap and saturate
        drive(1, 7, 1, 0, 1);  tick();
        drive(1, -8, 1, 0, 1); tick();
        drive(0, 0, 0, 0, 1);  tick();
        chk("ovf_sum_wrap", sum0, 8);
        chk("ovf_flag_wrap", ovf0, 1);
        chk("ovf_sum_sat", sum1, 7);
        chk("ovf_flag_sat", ovf1, 1);
        tick();
        chk("ovf_diff_sat", diff1, 8);
        chk("ovf_diff_sat_flag", ovf1, 1);
        chk("ovf_diff_wrap", diff0, 7);
        tick();

        // Clear with and without handshake
        drive(1, 3, 1, 0, 1); tick();
        drive(0, 0, 0, 0, 1); tick();
        tick();
        chk("clr_item_valid", out_valid0, 1);
        drive(0, 0, 0, 1, 1); tick();
        chk("clr_hs_acc", acc_o0, 4);
        chk("clr_hs_acc_sat", acc_o1, 4);
        chk("clr_alone_pre", out_valid0, 0);
        tick();
        chk("clr_alone_acc", acc_o0, 0);
        chk("clr_alone_acc_sat", acc_o1, 0);
        drive(0, 0, 0, 0, 1); tick();

        // Back-pressure with three items in flight
        drive(1, 1, 2, 0, 0);  tick();
        drive(1, -3, 2, 0, 0); tick();
        drive(1, 5, -4, 0, 0); tick();
        drive(1, 6, 6, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", in_ready0, 0);
            chk("stall_valid", out_valid0, 1);
            tick();
        end
        hs0 = n_hs;
        drive(0, 0, 0, 0, 1);
        tick(); tick(); tick();
        chk("stall_drained", n_hs - hs0, 3);
        chk("stall_idle", out_valid0, 0);

        // Randomized traffic with a reset pulse part-way through
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0));
            if (i == 200) begin
                reset = 1'b0;
                #1;
                check_reset_state("mid_rst");
                qa.delete();
                qb.delete();
                acc0 = 0;
                acc1 = 0;
                tick();
                tick();
                reset = 1'b1;
            end
            tick();
        end

        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < D + 3; i++) tick();
        chk("drain_empty", qa.size(), 0);
        chk("drain_idle", out_valid0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
